// File: rtl/psram_req_arbiter.sv
// psram_req_arbiter
//   Shares the single PSRAM controller command port between two requesters:
//   [0] the UART command decoder and [1] the self-test pattern engine.
//   Traffic is held off until PSRAM initialisation completes. Grants are
//   round-robin with one transaction outstanding at a time. Read data is
//   routed back to the owner, and accesses that never complete are aborted
//   after TIMEOUT cycles and counted in err_cnt.
//
// Ports
//   sys_clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   init_done               PSRAM init finished (level)
//   req_valid/we/addr/wdata per-requester command, packed {req1, req0}
//   req_ready               one-cycle accept pulse to the granted requester
//   rsp_valid/rdata/err     one-cycle completion to the owner
//   mem_start/we/addr/wdata command to PSRAM controller
//   mem_busy/done/rdata     controller handshake and read data
//   process                 FSM state code for logic-analyser probing
//   err_cnt                 saturating timeout count
module psram_req_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_start,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_busy,
  input  logic                  mem_done,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [3:0]            process,
  output logic [7:0]            err_cnt
);

  localparam int TIMER_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t              state_q,      state_d;
  logic                last_owner_q, last_owner_d;
  logic                owner_q,      owner_d;
  logic [1:0]          req_ready_q,  req_ready_d;
  logic [1:0]          rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q,  rsp_rdata_d;
  logic                rsp_err_q,    rsp_err_d;
  logic                mem_start_q,  mem_start_d;
  logic                mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [TIMER_W-1:0]  timer_q,      timer_d;
  logic [7:0]          err_cnt_q,    err_cnt_d;

  // Round-robin pick: prefer the requester that was not served last,
  // otherwise fall back to the one that is (only meaningful if any valid).
  logic grant;
  assign grant = req_valid[~last_owner_q] ? ~last_owner_q : last_owner_q;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    req_ready_d  = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    mem_start_d  = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    timer_d      = timer_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      S_WAIT_INIT: begin
        if (init_done) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (!init_done) begin
          state_d = S_WAIT_INIT;
        end else if (|req_valid) begin
          req_ready_d = grant ? 2'b10 : 2'b01;
          owner_d     = grant;
          mem_we_d    = req_we[grant];
          mem_addr_d  = grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          mem_wdata_d = grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!mem_busy) begin
          mem_start_d = 1'b1;
          timer_d     = '0;
          state_d     = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        timer_d = timer_q + TIMER_W'(1);
        // A completion arriving in the expiry cycle wins over the timeout.
        if (mem_done) begin
          rsp_rdata_d = mem_we_q ? '0 : mem_rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = S_RESP;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        // rsp_valid is high during this state; record who was served.
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_INIT;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      req_ready_q  <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      mem_start_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      timer_q      <= '0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      mem_start_q  <= mem_start_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      timer_q      <= timer_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_start = mem_start_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign process   = {1'b0, state_q};
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_psram_req_arbiter.sv
// tb_psram_req_arbiter
//   Drives two requesters and a behavioural PSRAM controller. Expected
//   responses are queued at grant time and compared when rsp_valid fires.
module tb_psram_req_arbiter;

  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic                sys_clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                init_done = 1'b0;
  logic [1:0]          req_valid = '0;
  logic [1:0]          req_ready;
  logic [1:0]          req_we = '0;
  logic [2*ADDR_W-1:0] req_addr = '0;
  logic [2*DATA_W-1:0] req_wdata = '0;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                mem_start;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_busy = 1'b0;
  logic                mem_done = 1'b0;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic [3:0]          process;
  logic [7:0]          err_cnt;

  psram_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .process(process), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int                owner;
    logic [DATA_W-1:0] rdata;
    bit                err;
  } exp_t;

  exp_t sb[$];
  int   grant_hist[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // requester model
  int                pending[2];
  logic              tb_we[2];
  logic [ADDR_W-1:0] tb_addr[2];
  logic [DATA_W-1:0] tb_wdata[2];

  // controller model: done_delay < 0 means never complete
  int                done_delay = 5;
  int                busy_len   = 0;
  int                busy_until = 0;
  logic [DATA_W-1:0] mem_rd_val = 16'h1234;
  bit                stray_done = 1'b0;
  bit                due_valid  = 1'b0;
  int                due_cyc    = 0;

  // transaction tracking
  bit                       active = 1'b0;
  bit                       started = 1'b0;
  logic [ADDR_W+DATA_W:0]   cur_cmd = '0;
  int grant_cyc = 0, start_cyc = 0, done_cyc = 0, busy_applied = 0;
  int model_last = 1;
  int model_err  = 0;
  int rsp_seen   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = (pending[i] > 0);
      req_we[i]    = tb_we[i];
      req_addr[i*ADDR_W +: ADDR_W]  = tb_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = tb_wdata[i];
    end
  endtask

  task automatic monitor(input logic [1:0] vld_at_edge);
    int   g;
    bit   e;
    exp_t x;
    if (req_ready != 2'b00) begin
      g = vld_at_edge[1 - model_last] ? 1 - model_last : model_last;
      check_eq("grant", req_ready, 64'd1 << g);
      check_eq("proc_issue", process, 4'd2);
      if (pending[g] > 0) pending[g]--;
      grant_hist.push_back(g);
      cur_cmd      = {tb_we[g], tb_addr[g], tb_wdata[g]};
      active       = 1'b1;
      grant_cyc    = cyc;
      busy_applied = busy_len;
      busy_until   = cyc + busy_len;
      e = !(done_delay >= 0 && done_delay <= TIMEOUT - 1);
      x.owner = g;
      x.err   = e;
      x.rdata = (e || tb_we[g]) ? '0 : mem_rd_val;
      sb.push_back(x);
      $display("cycle %0d: grant requester %0d we=%0b addr=0x%0h", cyc, g, tb_we[g], tb_addr[g]);
    end
    if (mem_start) begin
      check_eq("start_lat", cyc, grant_cyc + 1 + busy_applied);
      check_eq("proc_wait", process, 4'd3);
      start_cyc = cyc;
      started   = 1'b1;
      if (done_delay >= 0) begin
        due_valid = 1'b1;
        due_cyc   = cyc + done_delay;
      end
    end
    if (active) check_eq("mem_cmd", {mem_we, mem_addr, mem_wdata}, cur_cmd);
    if (rsp_valid != 2'b00) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        check_eq("unexpected_rsp", rsp_valid, 0);
      end else begin
        x = sb.pop_front();
        if (x.err && model_err < 255) model_err++;
        check_eq("rsp_owner", rsp_valid, 64'd1 << x.owner);
        check_eq("rsp_rdata", rsp_rdata, x.rdata);
        check_eq("rsp_err", rsp_err, x.err);
        check_eq("err_cnt", err_cnt, model_err);
        check_eq("proc_resp", process, 4'd4);
        if (x.err) check_eq("rsp_lat_timeout", cyc, start_cyc + TIMEOUT);
        else       check_eq("rsp_lat_done", cyc, done_cyc + 1);
        model_last = x.owner;
        $display("cycle %0d: rsp owner %0d rdata=0x%0h err=%0b err_cnt=%0d", cyc, x.owner, rsp_rdata, rsp_err, err_cnt);
      end
      active = 1'b0;
    end
  endtask

  // One clock: sample outputs 1ns after the edge, then drive next inputs.
  task automatic tick();
    logic [1:0] vld_at_edge;
    vld_at_edge = req_valid;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (rst_n) monitor(vld_at_edge);
    mem_done = (due_valid && cyc == due_cyc) || stray_done;
    if (due_valid && cyc == due_cyc) begin
      done_cyc  = cyc;
      due_valid = 1'b0;
    end
    stray_done = 1'b0;
    mem_rdata  = mem_rd_val;
    mem_busy   = (cyc < busy_until);
    drive_reqs();
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int target;
    int left;
    target = rsp_seen + n;
    left   = budget;
    while (rsp_seen < target && left > 0) begin
      tick();
      left--;
    end
    check_eq("rsp_count", rsp_seen, target);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, {req_ready, rsp_valid, rsp_rdata, rsp_err, mem_start, mem_we}, 0);
    check_eq({tag, "_b"}, {mem_addr, mem_wdata, err_cnt}, 0);
    check_eq({tag, "_proc"}, process, 0);
  endtask

  initial begin
    int first;
    int n;
    pending[0] = 0; pending[1] = 0;
    tb_we[0] = 1'b0; tb_addr[0] = 22'h000010; tb_wdata[0] = 16'h0000;
    tb_we[1] = 1'b1; tb_addr[1] = 22'h000020; tb_wdata[1] = 16'hBEEF;

    // reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // T1: no traffic before init_done
    pending[0] = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t1_hold", {req_ready, mem_start}, 0);
      check_eq("t1_proc", process, 4'd0);
    end
    init_done = 1'b1;
    tick();
    check_eq("t1_ready_early", req_ready, 0);
    check_eq("t1_proc_idle", process, 4'd1);
    tick();
    check_eq("t1_ready", req_ready, 2'b01);
    wait_rsps(1, 50);

    // T2: both requesters continuously valid, grants alternate
    grant_hist.delete();
    first = 1 - model_last;
    pending[0] = 2; pending[1] = 2;
    wait_rsps(4, 200);
    check_eq("t2_ngrants", grant_hist.size(), 4);
    for (int i = 0; i < grant_hist.size(); i++)
      check_eq("t2_alternate", grant_hist[i], (first + i) % 2);

    // T3: controller busy for 10 cycles at ISSUE
    busy_len = 10;
    pending[1] = 1;
    wait_rsps(1, 100);
    busy_len = 0;

    // T5: completion in the expiry cycle is a success
    done_delay = TIMEOUT - 1;
    pending[0] = 1;
    wait_rsps(1, 150);
    check_eq("t5_errcnt_unchanged", err_cnt, 0);

    // completion one cycle late is a timeout; the late pulse is ignored
    done_delay = TIMEOUT;
    pending[1] = 1;
    wait_rsps(1, 150);
    check_eq("t5_late_errcnt", err_cnt, 1);

    // T4: no completion at all, then saturate the error counter
    done_delay = -1;
    pending[1] = 1;
    wait_rsps(1, 150);
    check_eq("t4_errcnt", err_cnt, 2);
    pending[0] = 299;
    wait_rsps(299, 299 * 75);
    check_eq("t4_saturated", err_cnt, 255);

    // stray mem_done while idle
    repeat (3) tick();
    stray_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("stray_no_rsp", rsp_valid, 0);
      check_eq("stray_proc", process, 4'd1);
    end

    // T6: asynchronous reset during WAIT_DONE
    started = 1'b0;
    pending[1] = 1;
    n = 0;
    while (!started && n < 20) begin
      tick();
      n++;
    end
    check_eq("t6_started", started, 1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    sb.delete();
    active = 1'b0;
    due_valid = 1'b0;
    model_last = 1;
    model_err = 0;
    pending[0] = 0; pending[1] = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    done_delay = 5;
    tb_we[0] = 1'b1; tb_addr[0] = 22'h2AAAAA; tb_wdata[0] = 16'h5A5A;
    tb_we[1] = 1'b0; tb_addr[1] = 22'h155555; tb_wdata[1] = 16'h0000;
    mem_rd_val = 16'hC3A5;
    grant_hist.delete();
    pending[0] = 1; pending[1] = 1;
    wait_rsps(2, 100);
    check_eq("t6_ngrants", grant_hist.size(), 2);
    if (grant_hist.size() > 0) check_eq("t6_first_grant", grant_hist[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
